// File: rtl/inst_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit_pkg
// Shared RV32I definitions for the fetch/decode front end:
//   INST_W      instruction width
//   OP_*        major opcode values
//   imm_fmt_e   immediate encoding format of an instruction
//   imm_fmt_of  maps a major opcode to its immediate format
// No ports (package).
// ---------------------------------------------------------------------------
package inst_fetch_unit_pkg;

  localparam int INST_W = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  // R-type and unknown opcodes both carry no immediate; they are kept apart
  // so later decode stages can tell a legal register op from garbage.
  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] op);
    imm_fmt_e fmt;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: fmt = FMT_I;
      OP_STORE:                 fmt = FMT_S;
      OP_BRANCH:                fmt = FMT_B;
      OP_LUI, OP_AUIPC:         fmt = FMT_U;
      OP_JAL:                   fmt = FMT_J;
      OP_REG:                   fmt = FMT_R;
      default:                  fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_imm_gen.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit_imm_gen
// Purely combinational RV32I immediate extractor, shared by fetch and any
// later decode logic.
// Ports:
//   inst_i   [31:0]  raw instruction
//   imm32_o  [31:0]  sign-extended immediate for the instruction's format,
//                    zero for R-type and unrecognised opcodes
// ---------------------------------------------------------------------------
module inst_fetch_unit_imm_gen
  import inst_fetch_unit_pkg::*;
(
  input  logic [INST_W-1:0] inst_i,
  output logic [INST_W-1:0] imm32_o
);

  // Reassemble the scattered immediate bits for each encoding format.
  always_comb begin
    imm32_o = '0;
    case (imm_fmt_of(inst_i[6:0]))
      FMT_I: imm32_o = {{20{inst_i[31]}}, inst_i[31:20]};
      FMT_S: imm32_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      FMT_B: imm32_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                        inst_i[30:25], inst_i[11:8], 1'b0};
      FMT_U: imm32_o = {inst_i[31:12], 12'b0};
      FMT_J: imm32_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                        inst_i[20], inst_i[30:21], 1'b0};
      default: imm32_o = '0;
    endcase
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
// Owns the PC, drives a 1-cycle-latency synchronous instruction store and
// buffers returned words (with their PCs) in a FQ_DEPTH-entry queue whose
// head is offered to decode over a valid/ready handshake. A redirect loads
// a new PC and flushes the queue and any in-flight response.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   imem_req_o, imem_addr_o       read strobe and word address to the store
//   imem_rdata_i                  store data, valid the cycle after the req
//   redirect_valid_i/_pc_i        branch/jump target (bits [1:0] ignored)
//   out_valid_o, out_ready_i      decode handshake on the queue head
//   out_pc_o, out_inst_o          head PC and raw instruction
//   opcode_o .. funct7_o          RV32I field slices of the head
//   imm32_o                       sign-extended immediate of the head
// ---------------------------------------------------------------------------
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                FQ_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              imem_req_o,
  output logic [ADDR_W-3:0] imem_addr_o,
  input  logic [INST_W-1:0] imem_rdata_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_pc_o,
  output logic [INST_W-1:0] out_inst_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic [INST_W-1:0] imm32_o
);

  localparam int IDX_W = $clog2(FQ_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [INST_W-1:0] inst_mem_q [FQ_DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [FQ_DEPTH];

  logic [PTR_W-1:0]  count;
  logic [PTR_W-1:0]  count_after_pop;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              pop;
  logic              push;
  logic              issue;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count  = wr_ptr_q - rd_ptr_q;
  assign rd_idx = rd_ptr_q[IDX_W-1:0];
  assign wr_idx = wr_ptr_q[IDX_W-1:0];

  assign out_valid_o     = (count != '0);
  assign pop             = out_valid_o && out_ready_i;
  assign push            = inflight_q && !redirect_valid_i;
  assign count_after_pop = count - PTR_W'(pop);

  // Credit check: a request is only issued if its response is guaranteed a
  // slot, counting the response already in flight. rst_ni gates the strobe
  // so nothing is requested while reset is held.
  assign issue = rst_ni && !redirect_valid_i &&
                 ((count_after_pop + PTR_W'(inflight_q)) < PTR_W'(FQ_DEPTH));

  assign imem_req_o  = issue;
  assign imem_addr_o = issue ? pc_q[ADDR_W-1:2] : '0;

  // Next-state: redirect overrides everything, clearing the queue and
  // dropping the response from the previous cycle's request.
  always_comb begin
    pc_d          = pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    inflight_d    = issue;
    inflight_pc_d = pc_q;
    if (redirect_valid_i) begin
      pc_d     = redirect_pc_i & ~ADDR_W'(3);
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (issue) pc_d     = pc_q + ADDR_W'(4);
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
  end

  // Control state, asynchronously reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Queue storage needs no reset; entries are only visible via out_valid_o.
  always_ff @(posedge clk_i) begin
    if (push) begin
      inst_mem_q[wr_idx] <= imem_rdata_i;
      pc_mem_q[wr_idx]   <= inflight_pc_q;
    end
  end

  // The credit rule must make overflow impossible.
  always_ff @(posedge clk_i) begin
    if (rst_ni) assert (!(push && (count == PTR_W'(FQ_DEPTH))));
  end

  // Head outputs are forced to zero whenever the queue is empty.
  assign out_pc_o   = out_valid_o ? pc_mem_q[rd_idx]   : '0;
  assign out_inst_o = out_valid_o ? inst_mem_q[rd_idx] : '0;

  assign opcode_o = out_inst_o[6:0];
  assign rd_o     = out_inst_o[11:7];
  assign funct3_o = out_inst_o[14:12];
  assign rs1_o    = out_inst_o[19:15];
  assign rs2_o    = out_inst_o[24:20];
  assign funct7_o = out_inst_o[31:25];

  inst_fetch_unit_imm_gen u_imm_gen (
    .inst_i  (out_inst_o),
    .imm32_o (imm32_o)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_unit
// Directed bench for inst_fetch_unit (ADDR_W=8, RESET_PC=0x10, FQ_DEPTH=2)
// with a behavioural 1-cycle-latency instruction store.
// ---------------------------------------------------------------------------
module tb_inst_fetch_unit;

  logic        clk;
  logic        rstN;
  logic        imemReq;
  logic [5:0]  imemAddr;
  logic [31:0] imemRdata;
  logic        redirectValid;
  logic [7:0]  redirectPc;
  logic        outValid;
  logic        outReady;
  logic [7:0]  outPc;
  logic [31:0] outInst;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm32;

  logic [31:0] storeMem [64];
  int          total = 0;
  int          bad   = 0;

  logic [31:0] immInst [5];
  logic [31:0] immExp  [5];

  inst_fetch_unit #(
    .ADDR_W   (8),
    .RESET_PC (8'h10),
    .FQ_DEPTH (2)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rstN),
    .imem_req_o       (imemReq),
    .imem_addr_o      (imemAddr),
    .imem_rdata_i     (imemRdata),
    .redirect_valid_i (redirectValid),
    .redirect_pc_i    (redirectPc),
    .out_valid_o      (outValid),
    .out_ready_i      (outReady),
    .out_pc_o         (outPc),
    .out_inst_o       (outInst),
    .opcode_o         (opcode),
    .rd_o             (rd),
    .rs1_o            (rs1),
    .rs2_o            (rs2),
    .funct3_o         (funct3),
    .funct7_o         (funct7),
    .imm32_o          (imm32)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction store: word is returned the cycle after the req.
  always @(posedge clk) begin
    if (imemReq) imemRdata <= storeMem[imemAddr];
  end

  // Drive inputs for one cycle at the falling edge, then let outputs settle.
  task automatic applyStimulus(input logic rstIn, input logic rdyIn,
                               input logic redirIn, input logic [7:0] rpcIn);
    @(negedge clk);
    rstN          = rstIn;
    outReady      = rdyIn;
    redirectValid = redirIn;
    redirectPc    = rpcIn;
    #1;
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Directed test sequence, cycle by cycle.
  initial begin
    for (int n = 0; n < 64; n++) storeMem[n] = n;
    storeMem[0] = 32'h5A5A_0000;
    immInst[0] = 32'hFFF0_0093; immExp[0] = 32'hFFFF_FFFF;
    immInst[1] = 32'hFE00_0EE3; immExp[1] = 32'hFFFF_FFFC;
    immInst[2] = 32'h1234_50B7; immExp[2] = 32'h1234_5000;
    immInst[3] = 32'h00C0_006F; immExp[3] = 32'h0000_000C;
    immInst[4] = 32'h00B5_0533; immExp[4] = 32'h0000_0000;
    for (int n = 0; n < 5; n++) storeMem[40 + n] = immInst[n];

    imemRdata     = '0;
    rstN          = 1'b0;
    outReady      = 1'b1;
    redirectValid = 1'b0;
    redirectPc    = '0;

    $display("[TB] reset and first fetch");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("rst_req",   imemReq,  0);
    checkOutput("rst_valid", outValid, 0);
    checkOutput("rst_addr",  imemAddr, 0);
    checkOutput("rst_pc",    outPc,    0);
    checkOutput("rst_inst",  outInst,  0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("c0_req",  imemReq,  1);
    checkOutput("c0_addr", imemAddr, 4);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("c1_addr",  imemAddr, 5);
    checkOutput("c1_valid", outValid, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("c2_valid", outValid, 1);
    checkOutput("c2_pc",    outPc,    32'h10);
    checkOutput("c2_inst",  outInst,  4);
    checkOutput("c2_addr",  imemAddr, 6);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("c3_pc",   outPc,   32'h14);
    checkOutput("c3_inst", outInst, 5);

    $display("[TB] backpressure");
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("bp_req",   imemReq,  0);
      checkOutput("bp_valid", outValid, 1);
      checkOutput("bp_pc",    outPc,    32'h18);
      checkOutput("bp_inst",  outInst,  6);
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      checkOutput("rel_pc",   outPc,   32'h18 + 4 * k);
      checkOutput("rel_inst", outInst, 6 + k);
    end

    $display("[TB] redirect with request in flight");
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h43);
    checkOutput("rd_req", imemReq, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("rd_valid0", outValid, 0);
    checkOutput("rd_req1",   imemReq,  1);
    checkOutput("rd_addr",   imemAddr, 32'h10);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("rd_valid1", outValid, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("rd_valid2", outValid, 1);
    checkOutput("rd_pc",     outPc,    32'h40);
    checkOutput("rd_inst",   outInst,  16);

    $display("[TB] pc wrap");
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFC);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("wr_addr0", imemAddr, 32'h3F);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("wr_req1",  imemReq,  1);
    checkOutput("wr_addr1", imemAddr, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("wr_pc0",   outPc,   32'hFC);
    checkOutput("wr_inst0", outInst, 63);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("wr_pc1",   outPc,   0);
    checkOutput("wr_inst1", outInst, 32'h5A5A_0000);

    $display("[TB] immediate and field decode");
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hA0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
      checkOutput("imm_pc",   outPc,   32'hA0 + 4 * k);
      checkOutput("imm_inst", outInst, immInst[k]);
      checkOutput("imm_val",  imm32,   immExp[k]);
      if (k == 0) begin
        checkOutput("addi_op",  opcode, 7'h13);
        checkOutput("addi_rd",  rd,     1);
        checkOutput("addi_rs1", rs1,    0);
      end
      if (k == 1) checkOutput("beq_f7", funct7, 7'h7F);
      if (k == 4) begin
        checkOutput("add_op",  opcode, 7'h33);
        checkOutput("add_rd",  rd,     10);
        checkOutput("add_rs1", rs1,    10);
        checkOutput("add_rs2", rs2,    11);
        checkOutput("add_f3",  funct3, 0);
      end
    end

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("full_valid", outValid, 1);
    checkOutput("full_req",   imemReq,  0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("mr_valid", outValid, 0);
    checkOutput("mr_req",   imemReq,  0);
    checkOutput("mr_pc",    outPc,    0);
    checkOutput("mr_inst",  outInst,  0);
    checkOutput("mr_imm",   imm32,    0);
    checkOutput("mr_addr",  imemAddr, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("rs_req",  imemReq,  1);
    checkOutput("rs_addr", imemAddr, 4);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("rs_pc",   outPc,   32'h10);
    checkOutput("rs_inst", outInst, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
